acc_nest_unit: RTL and testbench

ACC_NEST_UNIT -- requirements
Module: acc_nest_unit

---
 rtl/acc_nest_unit.sv | 93 +++++++++
 tb/tb_acc_nest_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/acc_nest_unit.sv
// Accumulator with a LIFO nesting stack for IL-style "op(" / ")" evaluation.
// The accumulator loads from an immediate, the ALU or the stack top, and sticky flags record stack misuse.
module acc_nest_unit #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 accMuxSel,
  input  logic                       accWr,
  input  logic [IMM_W-1:0]           immData,
  input  logic [DATA_W-1:0]          aluOut,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       errClr,
  output logic [DATA_W-1:0]          accOut,
  output logic [DATA_W-1:0]          stackTop,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovfErr,
  output logic                       udfErr,
  output logic                       seqErr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LVL_W = IDX_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]  lvl_m1;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_set;
  logic              udf_set;
  logic              seq_set;
  logic [DATA_W-1:0] acc_next;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign lvl_m1   = level - LVL_W'(1);
  assign top_idx  = lvl_m1[IDX_W-1:0];
  assign wr_idx   = level[IDX_W-1:0];
  assign stackTop = empty ? '0 : mem[top_idx];

  // A simultaneous push and pop is a sequencing error, not a stack operation.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign ovf_set = push & ~pop & full;
  assign udf_set = pop & ~push & empty;
  assign seq_set = push & pop;

  always_comb begin
    acc_next = accOut;
    if (accWr) begin
      case (accMuxSel)
        2'd0:    acc_next = DATA_W'(immData);
        2'd1:    acc_next = aluOut;
        2'd2:    acc_next = stackTop;
        default: acc_next = accOut;
      endcase
    end
  end

  // Register stage: accumulator, occupancy and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accOut <= '0;
      level  <= '0;
      ovfErr <= 1'b0;
      udfErr <= 1'b0;
      seqErr <= 1'b0;
    end else begin
      accOut <= acc_next;
      if (push_ok)
        level <= level + LVL_W'(1);
      else if (pop_ok)
        level <= lvl_m1;
      ovfErr <= ovf_set | (ovfErr & ~errClr);
      udfErr <= udf_set | (udfErr & ~errClr);
      seqErr <= seq_set | (seqErr & ~errClr);
    end
  end

  // Stack entries carry data only; their contents are invisible while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && reset)
      mem[wr_idx] <= accOut;
  end

endmodule

// File: tb/tb_acc_nest_unit.sv
// Bench for acc_nest_unit: directed scenarios followed by random operation sequences,
// each cycle compared against a queue-based model of the accumulator and stack.
module tb_acc_nest_unit;

  localparam int DATA_W = 8;
  localparam int IMM_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        accMuxSel;
  logic              accWr;
  logic [IMM_W-1:0]  immData;
  logic [DATA_W-1:0] aluOut;
  logic              push;
  logic              pop;
  logic              errClr;
  logic [DATA_W-1:0] accOut;
  logic [DATA_W-1:0] stackTop;
  logic [2:0]        level;
  logic              full;
  logic              empty;
  logic              ovfErr;
  logic              udfErr;
  logic              seqErr;

  int total = 0;
  int bad   = 0;

  int m_acc;
  int m_stk[$];
  bit m_ovf, m_udf, m_seq;

  acc_nest_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .accMuxSel(accMuxSel), .accWr(accWr),
    .immData(immData), .aluOut(aluOut), .push(push), .pop(pop), .errClr(errClr),
    .accOut(accOut), .stackTop(stackTop), .level(level), .full(full), .empty(empty),
    .ovfErr(ovfErr), .udfErr(udfErr), .seqErr(seqErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    int top;
    top = (m_stk.size() != 0) ? m_stk[$] : 0;
    chk({tag, ".acc"},   32'(accOut),   32'(m_acc));
    chk({tag, ".top"},   32'(stackTop), 32'(top));
    chk({tag, ".level"}, 32'(level),    32'(m_stk.size()));
    chk({tag, ".full"},  32'(full),     32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),    32'(m_stk.size() == 0));
    chk({tag, ".ovf"},   32'(ovfErr),   32'(m_ovf));
    chk({tag, ".udf"},   32'(udfErr),   32'(m_udf));
    chk({tag, ".seq"},   32'(seqErr),   32'(m_seq));
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_stk.delete();
    m_ovf = 0; m_udf = 0; m_seq = 0;
  endtask

  // Reference behaviour: all effects computed from values seen before the edge.
  task automatic model_edge(input int sel, input bit wr, input int imm, input int alu,
                            input bit ps, input bit pp, input bit clr);
    int  top_before;
    bit  o, u, s;
    top_before = (m_stk.size() != 0) ? m_stk[$] : 0;
    o = 0; u = 0; s = 0;
    if (ps && pp) s = 1;
    else if (ps) begin
      if (m_stk.size() == DEPTH) o = 1;
      else m_stk.push_back(m_acc);
    end else if (pp) begin
      if (m_stk.size() == 0) u = 1;
      else void'(m_stk.pop_back());
    end
    m_ovf = o | (m_ovf & !clr);
    m_udf = u | (m_udf & !clr);
    m_seq = s | (m_seq & !clr);
    if (wr) begin
      if (sel == 0) m_acc = imm & 8'hFF;
      else if (sel == 1) m_acc = alu & 8'hFF;
      else if (sel == 2) m_acc = top_before;
    end
  endtask

  task automatic step(input string tag, input int sel, input bit wr, input int imm, input int alu,
                      input bit ps, input bit pp, input bit clr);
    accMuxSel = 2'(sel);
    accWr     = wr;
    immData   = 8'(imm);
    aluOut    = 8'(alu);
    push      = ps;
    pop       = pp;
    errClr    = clr;
    @(posedge clk);
    model_edge(sel, wr, imm, alu, ps, pp, clr);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    accMuxSel = 2'd3; accWr = 1'b0; immData = '0; aluOut = '0;
    push = 1'b0; pop = 1'b0; errClr = 1'b0;
  endtask

  initial begin
    int r;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b1;

    // Immediate load into empty-stack accumulator.
    step("imm_load", 0, 1, 8'h5A, 0, 0, 0, 0);

    // Save-and-load then restore from stack.
    step("acc11", 0, 1, 8'h11, 0, 0, 0, 0);
    step("push_alu", 1, 1, 0, 8'h22, 1, 0, 0);
    step("pop_load", 2, 1, 0, 0, 0, 1, 0);

    // Fill to DEPTH, overflow, then clear.
    step("acc01", 0, 1, 8'h01, 0, 0, 0, 0);
    step("push1", 0, 1, 8'h02, 0, 1, 0, 0);
    step("push2", 0, 1, 8'h03, 0, 1, 0, 0);
    step("push3", 0, 1, 8'h04, 0, 1, 0, 0);
    step("push4", 0, 1, 8'h05, 0, 1, 0, 0);
    step("push_ovf", 0, 0, 0, 0, 1, 0, 0);
    step("hold_sel3", 3, 1, 8'hEE, 8'hDD, 0, 0, 0);
    step("clr_ovf", 3, 0, 0, 0, 0, 0, 1);

    // Drain, then underflow with load from empty stack.
    step("pop_a", 2, 1, 0, 0, 0, 1, 0);
    step("pop_b", 3, 0, 0, 0, 0, 1, 0);
    step("pop_c", 3, 0, 0, 0, 0, 1, 0);
    step("pop_d", 3, 0, 0, 0, 0, 1, 0);
    step("pop_udf", 2, 1, 0, 0, 0, 1, 0);
    step("clr_udf", 3, 0, 0, 0, 0, 0, 1);

    // Collision at level 2, then clear racing a fresh underflow.
    step("pushA", 0, 1, 8'hA1, 0, 1, 0, 0);
    step("pushB", 0, 1, 8'hB2, 0, 1, 0, 0);
    step("collide", 1, 1, 0, 8'h3C, 1, 1, 0);
    step("popX", 3, 0, 0, 0, 0, 1, 0);
    step("popY", 3, 0, 0, 0, 0, 1, 0);
    step("clr_vs_udf", 3, 0, 0, 0, 0, 1, 1);

    // Random operation sequences.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      step("rand", $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 255), (r < 4) || (r == 8), (r >= 4 && r <= 8),
           ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-push at level 3.
    step("clr_pre", 3, 0, 0, 0, 0, 0, 1);
    while (m_stk.size() != 0) step("drain", 3, 0, 0, 0, 0, 1, 0);
    step("lvl1", 0, 1, 8'h31, 0, 1, 0, 0);
    step("lvl2", 0, 1, 8'h32, 0, 1, 0, 0);
    step("lvl3", 0, 1, 8'h33, 0, 1, 0, 0);
    accMuxSel = 2'd0; accWr = 1'b1; immData = 8'h77; push = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_edge");
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 0, 1, 8'hC3, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
